// File: rtl/voice_scheduler.sv
// voice_scheduler
// Shares one oscillator step unit across VOICES voices. Each sample_tick runs
// one round. A round gives every voice a fixed slot of OSC_LATENCY+1 cycles,
// stepping the oscillator once for each active voice. The round ends with the
// saturated sum of the new samples on mix_out.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for sample_tick
// LOAD    | voice_q state presented on osc_*, osc_load strobed if active
// WAIT    | oscillator latency padding (only when OSC_LATENCY > 1)
// STORE   | oscillator result written back and accumulated
// DONE    | saturated mix registered, mix_valid strobed
module voice_scheduler #(
    parameter int VOICES      = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAC_BITS   = 20,
    parameter int OSC_LATENCY = 1,
    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_tick,
    input  logic                  cfg_we,
    input  logic [VW-1:0]         cfg_voice,
    input  logic                  cfg_enable,
    input  logic [DATA_WIDTH-1:0] cfg_wave_length,
    input  logic                  cfg_restart,
    output logic                  osc_load,
    output logic [DATA_WIDTH-1:0] osc_sample,
    output logic [DATA_WIDTH-1:0] osc_counter,
    output logic [DATA_WIDTH-1:0] osc_wave_length,
    input  logic [DATA_WIDTH-1:0] osc_value,
    input  logic [DATA_WIDTH-1:0] osc_out_counter,
    output logic [DATA_WIDTH-1:0] mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  overrun
);

    // Accumulator width leaves headroom for VOICES full-scale samples plus sign.
    localparam int AW  = DATA_WIDTH + VW + 1;
    localparam int WCW = (OSC_LATENCY > 1) ? $clog2(OSC_LATENCY) : 1;

    localparam logic [DATA_WIDTH-1:0] SAMPLE_ONE   = DATA_WIDTH'(1) << FRAC_BITS;
    localparam logic [DATA_WIDTH-1:0] COUNTER_INIT = DATA_WIDTH'(1);
    localparam logic signed [AW-1:0]  SAT_MAX =
        {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0]  SAT_MIN =
        {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_STORE,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [VW-1:0]          voice_q;
    logic [WCW-1:0]         wait_q;
    logic                   active_q;
    logic signed [AW-1:0]   acc_q;

    logic                   osc_load_q;
    logic [DATA_WIDTH-1:0]  osc_sample_q;
    logic [DATA_WIDTH-1:0]  osc_counter_q;
    logic [DATA_WIDTH-1:0]  osc_wl_q;
    logic [DATA_WIDTH-1:0]  mix_out_q;
    logic                   mix_valid_q;
    logic                   busy_q;
    logic                   overrun_q;

    logic [DATA_WIDTH-1:0]  sample_q  [VOICES];
    logic [DATA_WIDTH-1:0]  counter_q [VOICES];
    logic [DATA_WIDTH-1:0]  wl_q      [VOICES];
    logic [VOICES-1:0]      en_q;

    logic [VW-1:0]          slot_d;
    logic [DATA_WIDTH-1:0]  slot_sample;
    logic [DATA_WIDTH-1:0]  slot_counter;
    logic [DATA_WIDTH-1:0]  slot_wl;
    logic                   slot_active;
    logic                   last_voice;
    logic signed [AW-1:0]   addend;
    logic signed [AW-1:0]   acc_d;
    logic [DATA_WIDTH-1:0]  mix_sat;
    logic                   store_wr;
    logic                   cfg_hit;

    // Next slot to present, its stored state, and the running sum including this STORE.
    always_comb begin
        slot_d       = (state_q == S_IDLE) ? '0 : voice_q + 1'b1;
        slot_sample  = sample_q[slot_d];
        slot_counter = counter_q[slot_d];
        slot_wl      = wl_q[slot_d];
        slot_active  = en_q[slot_d] && (wl_q[slot_d] != '0);
        last_voice   = (voice_q == VW'(VOICES - 1));
        addend       = active_q ? {{(AW-DATA_WIDTH){osc_value[DATA_WIDTH-1]}}, osc_value} : '0;
        acc_d        = acc_q + addend;
        store_wr     = (state_q == S_STORE) && active_q;
        cfg_hit      = cfg_we && ({1'b0, cfg_voice} < (VW+1)'(VOICES));
    end

    // Clamp the wide sum into the output word range.
    always_comb begin
        if (acc_d > SAT_MAX) begin
            mix_sat = SAT_MAX[DATA_WIDTH-1:0];
        end else if (acc_d < SAT_MIN) begin
            mix_sat = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            mix_sat = acc_d[DATA_WIDTH-1:0];
        end
    end

    // Round sequencer with registered oscillator, mix and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            voice_q       <= '0;
            wait_q        <= '0;
            active_q      <= 1'b0;
            acc_q         <= '0;
            osc_load_q    <= 1'b0;
            osc_sample_q  <= '0;
            osc_counter_q <= '0;
            osc_wl_q      <= '0;
            mix_out_q     <= '0;
            mix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            osc_load_q  <= 1'b0;
            mix_valid_q <= 1'b0;
            overrun_q   <= sample_tick && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (sample_tick) begin
                        state_q       <= S_LOAD;
                        busy_q        <= 1'b1;
                        voice_q       <= slot_d;
                        active_q      <= slot_active;
                        osc_load_q    <= slot_active;
                        osc_sample_q  <= slot_sample;
                        osc_counter_q <= slot_counter;
                        osc_wl_q      <= slot_wl;
                    end
                end
                S_LOAD: begin
                    if (OSC_LATENCY == 1) begin
                        state_q <= S_STORE;
                    end else begin
                        state_q <= S_WAIT;
                        wait_q  <= WCW'(OSC_LATENCY - 1);
                    end
                end
                S_WAIT: begin
                    if (wait_q == WCW'(1)) begin
                        state_q <= S_STORE;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                S_STORE: begin
                    if (last_voice) begin
                        state_q     <= S_DONE;
                        mix_out_q   <= mix_sat;
                        mix_valid_q <= 1'b1;
                        acc_q       <= '0;
                    end else begin
                        state_q       <= S_LOAD;
                        acc_q         <= acc_d;
                        voice_q       <= slot_d;
                        active_q      <= slot_active;
                        osc_load_q    <= slot_active;
                        osc_sample_q  <= slot_sample;
                        osc_counter_q <= slot_counter;
                        osc_wl_q      <= slot_wl;
                    end
                end
                S_DONE: begin
                    state_q  <= S_IDLE;
                    busy_q   <= 1'b0;
                    active_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-voice storage: config writes, restart, and oscillator writeback (restart wins).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q <= '0;
            for (int i = 0; i < VOICES; i++) begin
                sample_q[i]  <= SAMPLE_ONE;
                counter_q[i] <= COUNTER_INIT;
                wl_q[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (cfg_hit && (cfg_voice == VW'(i))) begin
                    en_q[i] <= cfg_enable;
                    wl_q[i] <= cfg_wave_length;
                end
                if (cfg_hit && (cfg_voice == VW'(i)) && cfg_restart) begin
                    sample_q[i]  <= SAMPLE_ONE;
                    counter_q[i] <= COUNTER_INIT;
                end else if (store_wr && (voice_q == VW'(i))) begin
                    sample_q[i]  <= osc_value;
                    counter_q[i] <= osc_out_counter;
                end
            end
        end
    end

    assign osc_load        = osc_load_q;
    assign osc_sample      = osc_sample_q;
    assign osc_counter     = osc_counter_q;
    assign osc_wave_length = osc_wl_q;
    assign mix_out         = mix_out_q;
    assign mix_valid       = mix_valid_q;
    assign busy            = busy_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with a behavioural square-wave step unit.
module tb_voice_scheduler;

    localparam int VOICES = 4;
    localparam int DW     = 22;
    localparam int FRAC   = 20;
    localparam int ONE    = 1 << FRAC;
    localparam int SAT_HI = (1 << (DW - 1)) - 1;
    localparam int SAT_LO = -(1 << (DW - 1));

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sample_tick = 1'b0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_voice = '0;
    logic          cfg_enable = 1'b0;
    logic [DW-1:0] cfg_wave_length = '0;
    logic          cfg_restart = 1'b0;
    logic          osc_load;
    logic [DW-1:0] osc_sample, osc_counter, osc_wave_length;
    logic [DW-1:0] osc_value = '0;
    logic [DW-1:0] osc_out_counter = '0;
    logic [DW-1:0] mix_out;
    logic          mix_valid, busy, overrun;

    int n_cmp = 0;
    int n_err = 0;

    logic          cap_load [VOICES];
    logic [DW-1:0] cap_smp  [VOICES];
    logic [DW-1:0] cap_cnt  [VOICES];
    logic [DW-1:0] cap_wl   [VOICES];
    logic [DW-1:0] cap_mix;
    int            cap_mv_cnt, cap_mv_cyc;

    voice_scheduler #(
        .VOICES(VOICES), .DATA_WIDTH(DW), .FRAC_BITS(FRAC), .OSC_LATENCY(1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
        .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_enable(cfg_enable),
        .cfg_wave_length(cfg_wave_length), .cfg_restart(cfg_restart),
        .osc_load(osc_load), .osc_sample(osc_sample), .osc_counter(osc_counter),
        .osc_wave_length(osc_wave_length), .osc_value(osc_value),
        .osc_out_counter(osc_out_counter), .mix_out(mix_out), .mix_valid(mix_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Square step: flip the sample once the counter reaches half the wave length.
    always @(posedge clk) begin
        if (osc_load) begin
            if ($signed(osc_counter) >= ($signed(osc_wave_length) >>> 1)) begin
                osc_value       <= -osc_sample;
                osc_out_counter <= DW'(1);
            end else begin
                osc_value       <= osc_sample;
                osc_out_counter <= osc_counter + DW'(1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cfg_write(input int v, input logic en, input int wl, input logic rs);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_voice = 2'(v); cfg_enable = en;
        cfg_wave_length = DW'(wl); cfg_restart = rs;
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_restart = 1'b0;
    endtask

    // Tick in cycle t, then capture slot LOAD cycles (t+1+2i) and mix_valid over t+1..t+12.
    task automatic run_round();
        cap_mv_cnt = 0; cap_mv_cyc = -1; cap_mix = '0;
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if ((c % 2) == 1 && c <= 2 * VOICES - 1) begin
                cap_load[(c-1)/2] = osc_load;
                cap_smp[(c-1)/2]  = osc_sample;
                cap_cnt[(c-1)/2]  = osc_counter;
                cap_wl[(c-1)/2]   = osc_wave_length;
            end
            if (mix_valid) begin
                cap_mv_cnt++; cap_mv_cyc = c; cap_mix = mix_out;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (osc_load !== 1'b0) begin n_err++; $display("FAIL reset_osc_load: got %b want 0", osc_load); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL reset_mix_out: got %0h want 0", mix_out); end
        n_cmp++; if (mix_valid !== 1'b0 || overrun !== 1'b0) begin n_err++; $display("FAIL reset_strobes: got mv=%b ov=%b want 0 0", mix_valid, overrun); end
        n_cmp++; if (osc_sample !== '0) begin n_err++; $display("FAIL reset_osc_sample: got %0h want 0", osc_sample); end
        cfg_write(0, 1'b1, 4, 1'b0);
        run_round();
        n_cmp++; if (cap_load[0] !== 1'b1) begin n_err++; $display("FAIL first_load: got %b want 1", cap_load[0]); end
        n_cmp++; if (cap_smp[0] !== DW'(ONE)) begin n_err++; $display("FAIL first_sample: got %0d want %0d", $signed(cap_smp[0]), ONE); end
        n_cmp++; if (cap_cnt[0] !== DW'(1)) begin n_err++; $display("FAIL first_counter: got %0d want 1", cap_cnt[0]); end
        n_cmp++; if (cap_wl[0] !== DW'(4)) begin n_err++; $display("FAIL first_wl: got %0d want 4", cap_wl[0]); end
        n_cmp++; if (cap_mv_cnt !== 1 || cap_mv_cyc !== 9) begin n_err++; $display("FAIL latency: got count=%0d cycle=%0d want 1 9", cap_mv_cnt, cap_mv_cyc); end
        n_cmp++; if (cap_mix !== DW'(ONE)) begin n_err++; $display("FAIL first_mix: got %0d want %0d", $signed(cap_mix), ONE); end
        run_round();
        n_cmp++; if (cap_cnt[0] !== DW'(2)) begin n_err++; $display("FAIL second_counter: got %0d want 2", cap_cnt[0]); end
        n_cmp++; if (cap_mix !== DW'(-ONE)) begin n_err++; $display("FAIL second_mix: got %0d want %0d", $signed(cap_mix), -ONE); end
    endtask

    task automatic test_single_voice();
        int exp_mix [6] = '{-1, 1, 1, -1, -1, 1};
        int exp_smp [6] = '{-1, -1, 1, 1, -1, -1};
        int exp_cnt [6] = '{1, 2, 1, 2, 1, 2};
        for (int r = 0; r < 6; r++) begin
            run_round();
            n_cmp++; if ({cap_load[3], cap_load[2], cap_load[1], cap_load[0]} !== 4'b0001) begin
                n_err++; $display("FAIL single_loads r%0d: got %b%b%b%b want 0001", r, cap_load[3], cap_load[2], cap_load[1], cap_load[0]); end
            n_cmp++; if (cap_smp[0] !== DW'(exp_smp[r] * ONE)) begin
                n_err++; $display("FAIL single_sample r%0d: got %0d want %0d", r, $signed(cap_smp[0]), exp_smp[r] * ONE); end
            n_cmp++; if (cap_cnt[0] !== DW'(exp_cnt[r])) begin
                n_err++; $display("FAIL single_counter r%0d: got %0d want %0d", r, cap_cnt[0], exp_cnt[r]); end
            n_cmp++; if (cap_mv_cnt !== 1 || cap_mix !== DW'(exp_mix[r] * ONE)) begin
                n_err++; $display("FAIL single_mix r%0d: got %0d (valid x%0d) want %0d", r, $signed(cap_mix), cap_mv_cnt, exp_mix[r] * ONE); end
        end
    endtask

    task automatic test_two_voices();
        int exp_mix [4] = '{0, 0, SAT_LO, SAT_HI};
        int s0 [4] = '{1, 1, -1, -1};
        int c0 [4] = '{1, 2, 1, 2};
        int s1 [4] = '{1, -1, 1, -1};
        cfg_write(1, 1'b1, 2, 1'b0);
        for (int r = 0; r < 4; r++) begin
            run_round();
            n_cmp++; if ({cap_load[3], cap_load[2], cap_load[1], cap_load[0]} !== 4'b0011) begin
                n_err++; $display("FAIL two_loads r%0d: got %b%b%b%b want 0011", r, cap_load[3], cap_load[2], cap_load[1], cap_load[0]); end
            n_cmp++; if (cap_wl[0] !== DW'(4) || cap_wl[1] !== DW'(2)) begin
                n_err++; $display("FAIL two_wl r%0d: got %0d %0d want 4 2", r, cap_wl[0], cap_wl[1]); end
            n_cmp++; if (cap_smp[0] !== DW'(s0[r] * ONE) || cap_cnt[0] !== DW'(c0[r])) begin
                n_err++; $display("FAIL two_v0_state r%0d: got %0d/%0d want %0d/%0d", r, $signed(cap_smp[0]), cap_cnt[0], s0[r] * ONE, c0[r]); end
            n_cmp++; if (cap_smp[1] !== DW'(s1[r] * ONE) || cap_cnt[1] !== DW'(1)) begin
                n_err++; $display("FAIL two_v1_state r%0d: got %0d/%0d want %0d/1", r, $signed(cap_smp[1]), cap_cnt[1], s1[r] * ONE); end
            n_cmp++; if (cap_mix !== DW'(exp_mix[r])) begin
                n_err++; $display("FAIL two_mix r%0d: got %0d want %0d", r, $signed(cap_mix), exp_mix[r]); end
        end
    endtask

    task automatic test_overrun();
        logic exp_ov, exp_mv, exp_busy;
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1 sample_tick = (c == 0 || c == 3 || c == 10);
            @(negedge clk);
            exp_ov   = (c == 4);
            exp_mv   = (c == 9 || c == 19);
            exp_busy = (c >= 1 && c <= 9) || (c >= 11 && c <= 19);
            n_cmp++; if (overrun !== exp_ov) begin n_err++; $display("FAIL overrun c%0d: got %b want %b", c, overrun, exp_ov); end
            n_cmp++; if (mix_valid !== exp_mv) begin n_err++; $display("FAIL ovr_mix_valid c%0d: got %b want %b", c, mix_valid, exp_mv); end
            n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL ovr_busy c%0d: got %b want %b", c, busy, exp_busy); end
            if (exp_mv) begin
                n_cmp++; if (mix_out !== '0) begin n_err++; $display("FAIL ovr_mix c%0d: got %0d want 0", c, $signed(mix_out)); end
            end
        end
        sample_tick = 1'b0;
    endtask

    task automatic test_cfg_during_load();
        int mv;
        cfg_write(1, 1'b0, 2, 1'b0);
        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        cfg_we = 1'b1; cfg_voice = 2'd0; cfg_enable = 1'b1; cfg_wave_length = DW'(8);
        @(negedge clk);
        n_cmp++; if (osc_load !== 1'b1 || osc_wave_length !== DW'(4)) begin
            n_err++; $display("FAIL cfg_load_slot: got load=%b wl=%0d want 1 4", osc_load, osc_wave_length); end
        @(posedge clk); #1 cfg_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (osc_wave_length !== DW'(4) || osc_sample !== DW'(-ONE)) begin
            n_err++; $display("FAIL cfg_store_slot: got wl=%0d smp=%0d want 4 %0d", osc_wave_length, $signed(osc_sample), -ONE); end
        mv = 0;
        for (int c = 3; c <= 12; c++) begin
            @(negedge clk);
            if (mix_valid) begin
                mv++;
                n_cmp++; if (mix_out !== DW'(-ONE)) begin n_err++; $display("FAIL cfg_mix: got %0d want %0d", $signed(mix_out), -ONE); end
            end
        end
        n_cmp++; if (mv !== 1) begin n_err++; $display("FAIL cfg_mix_count: got %0d want 1", mv); end
        run_round();
        n_cmp++; if (cap_wl[0] !== DW'(8)) begin n_err++; $display("FAIL cfg_next_wl: got %0d want 8", cap_wl[0]); end
        n_cmp++; if (cap_smp[0] !== DW'(-ONE) || cap_cnt[0] !== DW'(2)) begin
            n_err++; $display("FAIL cfg_next_state: got %0d/%0d want %0d/2", $signed(cap_smp[0]), cap_cnt[0], -ONE); end
        n_cmp++; if ({cap_load[3], cap_load[2], cap_load[1], cap_load[0]} !== 4'b0001) begin
            n_err++; $display("FAIL cfg_next_loads: got %b%b%b%b want 0001", cap_load[3], cap_load[2], cap_load[1], cap_load[0]); end
    endtask

    task automatic test_saturation_and_reset();
        int mv;
        for (int v = 0; v < VOICES; v++) cfg_write(v, 1'b1, 100, 1'b1);
        run_round();
        n_cmp++; if ({cap_load[3], cap_load[2], cap_load[1], cap_load[0]} !== 4'b1111) begin
            n_err++; $display("FAIL sat_loads: got %b%b%b%b want 1111", cap_load[3], cap_load[2], cap_load[1], cap_load[0]); end
        for (int v = 0; v < VOICES; v++) begin
            n_cmp++; if (cap_smp[v] !== DW'(ONE) || cap_cnt[v] !== DW'(1)) begin
                n_err++; $display("FAIL sat_restart_v%0d: got %0d/%0d want %0d/1", v, $signed(cap_smp[v]), cap_cnt[v], ONE); end
        end
        n_cmp++; if (cap_mix !== DW'(SAT_HI)) begin n_err++; $display("FAIL sat_mix: got %0d want %0d", $signed(cap_mix), SAT_HI); end

        @(posedge clk); #1 sample_tick = 1'b1;
        @(posedge clk); #1 sample_tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || osc_load !== 1'b0 || mix_out !== '0) begin
            n_err++; $display("FAIL midreset_outputs: got busy=%b load=%b mix=%0d want 0 0 0", busy, osc_load, $signed(mix_out)); end
        @(posedge clk);
        @(posedge clk); #1 reset_n = 1'b1;
        mv = 0;
        repeat (12) begin
            @(negedge clk);
            if (mix_valid) mv++;
        end
        n_cmp++; if (mv !== 0 || busy !== 1'b0) begin n_err++; $display("FAIL midreset_no_mix: got count=%0d busy=%b want 0 0", mv, busy); end
        cfg_write(0, 1'b1, 4, 1'b0);
        run_round();
        n_cmp++; if ({cap_load[3], cap_load[2], cap_load[1], cap_load[0]} !== 4'b0001) begin
            n_err++; $display("FAIL postreset_loads: got %b%b%b%b want 0001", cap_load[3], cap_load[2], cap_load[1], cap_load[0]); end
        n_cmp++; if (cap_smp[0] !== DW'(ONE) || cap_cnt[0] !== DW'(1)) begin
            n_err++; $display("FAIL postreset_state: got %0d/%0d want %0d/1", $signed(cap_smp[0]), cap_cnt[0], ONE); end
        n_cmp++; if (cap_mv_cnt !== 1 || cap_mix !== DW'(ONE)) begin
            n_err++; $display("FAIL postreset_mix: got %0d (valid x%0d) want %0d", $signed(cap_mix), cap_mv_cnt, ONE); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_two_voices();
        test_overrun();
        test_cfg_during_load();
        test_saturation_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
